// File: rtl/or1200_dc_biu_responder.sv
// Data-cache side BIU responder: answers single/4-beat read and write requests
// from a local word memory with programmable latency, beat gaps and an error window.
module or1200_dc_biu_responder #(
  parameter int          AW       = 6,
  parameter int          LATENCY  = 2,
  parameter int          BEAT_GAP = 0,
  parameter logic [31:0] ERR_BASE = 32'hFFFF0000,
  parameter logic [31:0] ERR_MASK = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        biu_read,
  input  logic        biu_write,
  input  logic        burst,
  input  logic [31:0] dc_addr,
  input  logic [3:0]  biu_sel,
  input  logic [31:0] biu_dat_i,
  output logic        biudata_valid,
  output logic        biudata_error,
  output logic [31:0] biu_dat_o,
  output logic [2:0]  dbg_state_o
);

  // Handshake: the requester holds biu_read or biu_write (never both) until it
  // sees the final biudata_valid or a biudata_error; dropping it early aborts.
  // Each biudata_valid pulse is one beat, registered, never overlapping an error.

  localparam int DEPTH = 1 << AW;
  localparam int WCW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WCW-1:0] WAIT_INIT = WCW'(LATENCY - 1);
  localparam logic [2:0]     GAP_INIT  = (BEAT_GAP > 0) ? 3'(BEAT_GAP - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_BEAT = 3'd2,
    S_GAP  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_base_q, idx_base_d;
  logic            rw_q, rw_d;
  logic            err_hit_q, err_hit_d;
  logic [1:0]      beats_left_q, beats_left_d;
  logic [1:0]      beat_idx_q, beat_idx_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [2:0]      gcnt_q, gcnt_d;
  logic            valid_q, valid_d;
  logic            error_q, error_d;
  logic [31:0]     dat_q, dat_d;
  logic            mem_we;

  logic [31:0]     mem_q [DEPTH];

  logic            req_live;
  logic [1:0]      word_off;
  logic [AW-1:0]   beat_index;

  // Wrap stays inside the 16-byte line: only the word offset advances.
  assign word_off   = idx_base_q[1:0] + beat_idx_q;
  assign beat_index = {idx_base_q[AW-1:2], word_off};
  assign req_live   = rw_q ? biu_write : biu_read;

  always_comb begin
    state_d      = state_q;
    idx_base_d   = idx_base_q;
    rw_d         = rw_q;
    err_hit_d    = err_hit_q;
    beats_left_d = beats_left_q;
    beat_idx_d   = beat_idx_q;
    wcnt_d       = wcnt_q;
    gcnt_d       = gcnt_q;
    valid_d      = 1'b0;
    error_d      = 1'b0;
    dat_d        = dat_q;
    mem_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (biu_read && biu_write) begin
          state_d = S_ERR;
        end else if (biu_read || biu_write) begin
          state_d      = S_WAIT;
          idx_base_d   = dc_addr[AW+1:2];
          rw_d         = biu_write;
          err_hit_d    = ((dc_addr & ERR_MASK) == ERR_BASE);
          beats_left_d = burst ? 2'd3 : 2'd0;
          beat_idx_d   = 2'd0;
          wcnt_d       = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (!req_live) begin
          state_d = S_IDLE;
        end else if (wcnt_q == '0) begin
          state_d = err_hit_q ? S_ERR : S_BEAT;
        end else begin
          wcnt_d = wcnt_q - WCW'(1);
        end
      end
      S_BEAT: begin
        if (!req_live) begin
          state_d = S_IDLE;
        end else begin
          valid_d    = 1'b1;
          mem_we     = rw_q;
          beat_idx_d = beat_idx_q + 2'd1;
          if (!rw_q) begin
            dat_d = mem_q[beat_index];
          end
          if (beats_left_q == 2'd0) begin
            state_d = S_IDLE;
          end else begin
            beats_left_d = beats_left_q - 2'd1;
            if (BEAT_GAP == 0) begin
              state_d = S_BEAT;
            end else begin
              state_d = S_GAP;
              gcnt_d  = GAP_INIT;
            end
          end
        end
      end
      S_GAP: begin
        if (!req_live) begin
          state_d = S_IDLE;
        end else if (gcnt_q == 3'd0) begin
          state_d = S_BEAT;
        end else begin
          gcnt_d = gcnt_q - 3'd1;
        end
      end
      S_ERR: begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_base_q   <= '0;
      rw_q         <= 1'b0;
      err_hit_q    <= 1'b0;
      beats_left_q <= 2'd0;
      beat_idx_q   <= 2'd0;
      wcnt_q       <= '0;
      gcnt_q       <= 3'd0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      dat_q        <= 32'd0;
    end else begin
      state_q      <= state_d;
      idx_base_q   <= idx_base_d;
      rw_q         <= rw_d;
      err_hit_q    <= err_hit_d;
      beats_left_q <= beats_left_d;
      beat_idx_q   <= beat_idx_d;
      wcnt_q       <= wcnt_d;
      gcnt_q       <= gcnt_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
      dat_q        <= dat_d;
    end
  end

  // Memory is deliberately not reset; mem_we is low while reset holds IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (biu_sel[i]) begin
          mem_q[beat_index][8*i +: 8] <= biu_dat_i[8*i +: 8];
        end
      end
    end
  end

  assign biudata_valid = valid_q;
  assign biudata_error = error_q;
  assign biu_dat_o     = dat_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_or1200_dc_biu_responder.sv
// Directed bench for or1200_dc_biu_responder (LATENCY=2, BEAT_GAP=1) with a
// reference word model and an expected-read-data queue.
module tb_or1200_dc_biu_responder;

  localparam int AW  = 6;
  localparam int LAT = 2;
  localparam int GAP = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        biu_read = 1'b0;
  logic        biu_write = 1'b0;
  logic        burst = 1'b0;
  logic [31:0] dc_addr = 32'd0;
  logic [3:0]  biu_sel = 4'd0;
  logic [31:0] biu_dat_i = 32'd0;
  logic        biudata_valid;
  logic        biudata_error;
  logic [31:0] biu_dat_o;
  logic [2:0]  dbg_state;

  logic [31:0] model_mem [1 << AW];
  logic [31:0] exp_q [$];
  logic [31:0] wdat [4];
  int          checks = 0;
  int          errors = 0;

  or1200_dc_biu_responder #(
    .AW(AW), .LATENCY(LAT), .BEAT_GAP(GAP),
    .ERR_BASE(32'hFFFF0000), .ERR_MASK(32'hFFFF0000)
  ) dut (
    .clk(clk), .rst(rst),
    .biu_read(biu_read), .biu_write(biu_write), .burst(burst),
    .dc_addr(dc_addr), .biu_sel(biu_sel), .biu_dat_i(biu_dat_i),
    .biudata_valid(biudata_valid), .biudata_error(biudata_error),
    .biu_dat_o(biu_dat_o), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] addr, input int k);
    logic [1:0] w;
    w = addr[3:2] + 2'(k);
    return int'({addr[AW+1:4], w});
  endfunction

  task automatic commit(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // One complete transfer; cycle 0 is the accept edge.
  task automatic xfer(input string tag, input logic wr, input logic bst,
                      input logic [31:0] addr, input logic [3:0] sel, input logic expect_err);
    int   nb, cyc, got;
    logic seen_err;
    nb = bst ? 4 : 1;
    if (!wr && !expect_err) begin
      for (int k = 0; k < nb; k++) exp_q.push_back(model_mem[widx(addr, k)]);
    end
    biu_read = !wr; biu_write = wr; burst = bst; dc_addr = addr;
    biu_sel = sel; biu_dat_i = wdat[0];
    step();
    cyc = 0; got = 0; seen_err = 1'b0;
    while (got < nb && !seen_err && cyc < 40) begin
      step();
      cyc++;
      if (biudata_valid) begin
        chk({tag, "_vcyc"}, cyc, LAT + 1 + got * (GAP + 1));
        if (wr) commit(widx(addr, got), wdat[got], sel);
        else    chk({tag, "_data"}, biu_dat_o, exp_q.pop_front());
        got++;
        if (got < 4) biu_dat_i = wdat[got];
      end
      if (biudata_error) begin
        seen_err = 1'b1;
        chk({tag, "_ecyc"}, cyc, LAT + 1);
      end
    end
    if (expect_err) begin
      chk({tag, "_err"}, 32'(seen_err), 32'd1);
      chk({tag, "_nvalid"}, got, 0);
    end else begin
      chk({tag, "_beats"}, got, nb);
      chk({tag, "_noerr"}, 32'(seen_err), 32'd0);
    end
    biu_read = 1'b0; biu_write = 1'b0;
    step();
  endtask

  initial begin
    int cyc, got, quiet, first_c, second_c;

    // Reset state
    repeat (3) step();
    chk("rst_valid", 32'(biudata_valid), 32'd0);
    chk("rst_error", 32'(biudata_error), 32'd0);
    chk("rst_dat", biu_dat_o, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    step();

    // Single write then single read of word 5, plus an aliased read
    wdat[0] = 32'hCAFEF00D;
    xfer("wr5", 1'b1, 1'b0, 32'h14, 4'hF, 1'b0);
    xfer("rd5", 1'b0, 1'b0, 32'h14, 4'hF, 1'b0);
    xfer("rd5_alias", 1'b0, 1'b0, 32'h114, 4'hF, 1'b0);

    // Burst write line at 0x30, burst read wrapping from 0x38 (words 14,15,12,13)
    wdat = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
    xfer("bwr30", 1'b1, 1'b1, 32'h30, 4'hF, 1'b0);
    xfer("brd38", 1'b0, 1'b1, 32'h38, 4'hF, 1'b0);

    // Byte-enable merge: 0xAABBCCDD with sel 0101 of 0x11223344 reads 0xAA22CC44
    wdat[0] = 32'hAABBCCDD;
    xfer("wr40_full", 1'b1, 1'b0, 32'h40, 4'hF, 1'b0);
    wdat[0] = 32'h11223344;
    xfer("wr40_sel", 1'b1, 1'b0, 32'h40, 4'b0101, 1'b0);
    xfer("rd40", 1'b0, 1'b0, 32'h40, 4'hF, 1'b0);

    // Error window read
    xfer("errwin", 1'b0, 1'b0, 32'hFFFF0010, 4'hF, 1'b1);

    // read and write together: error one cycle after the sampling edge
    biu_read = 1'b1; biu_write = 1'b1; dc_addr = 32'h14;
    step();
    cyc = 0; got = 0; first_c = -1;
    while (first_c < 0 && cyc < 10) begin
      step();
      cyc++;
      if (biudata_valid) got++;
      if (biudata_error) first_c = cyc;
    end
    biu_read = 1'b0; biu_write = 1'b0;
    chk("rw_both_ecyc", first_c, 1);
    chk("rw_both_nvalid", got, 0);
    step();

    // Abort during WAIT: nothing comes back, next read is accepted at once
    biu_read = 1'b1; dc_addr = 32'h14; burst = 1'b0;
    step();
    step();
    biu_read = 1'b0;
    quiet = 0;
    repeat (6) begin
      step();
      if (biudata_valid || biudata_error) quiet++;
    end
    chk("abort_quiet", quiet, 0);
    chk("abort_state", 32'(dbg_state), 32'd0);
    xfer("rd_after_abort", 1'b0, 1'b0, 32'h14, 4'hF, 1'b0);

    // Request held after completion is re-accepted back-to-back
    exp_q.push_back(model_mem[5]);
    exp_q.push_back(model_mem[5]);
    biu_read = 1'b1; dc_addr = 32'h14; burst = 1'b0;
    step();
    cyc = 0; first_c = -1; second_c = -1;
    while (second_c < 0 && cyc < 20) begin
      step();
      cyc++;
      if (biudata_valid) begin
        chk("b2b_data", biu_dat_o, exp_q.pop_front());
        if (first_c < 0) first_c = cyc;
        else second_c = cyc;
      end
    end
    biu_read = 1'b0;
    chk("b2b_first", first_c, LAT + 1);
    chk("b2b_second", second_c, 2 * (LAT + 2) - 1);
    step();

    // Reset in the middle of a burst write; committed beats survive
    wdat = '{32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'hD3D3D3D3};
    xfer("bwr50_pre", 1'b1, 1'b1, 32'h50, 4'hF, 1'b0);
    wdat = '{32'hE0E0E0E0, 32'hE1E1E1E1, 32'hE2E2E2E2, 32'hE3E3E3E3};
    biu_write = 1'b1; burst = 1'b1; dc_addr = 32'h50; biu_sel = 4'hF; biu_dat_i = wdat[0];
    step();
    cyc = 0; got = 0;
    while (got < 2 && cyc < 20) begin
      step();
      cyc++;
      if (biudata_valid) begin
        commit(widx(32'h50, got), wdat[got], 4'hF);
        got++;
        biu_dat_i = wdat[got];
      end
    end
    chk("rstmid_beats", got, 2);
    rst = 1'b0;
    #1;
    chk("rstmid_valid", 32'(biudata_valid), 32'd0);
    chk("rstmid_error", 32'(biudata_error), 32'd0);
    chk("rstmid_dat", biu_dat_o, 32'd0);
    chk("rstmid_state", 32'(dbg_state), 32'd0);
    step();
    biu_write = 1'b0; burst = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("rstrel_state", 32'(dbg_state), 32'd0);
    xfer("brd50", 1'b0, 1'b1, 32'h50, 4'hF, 1'b0);

    chk("expq_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
